// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer: Moore FSM stepping each instruction through
// fetch, decode, execute, memory and write-back, with illegal-opcode and memory-timeout traps.
module multicycle_control #(
    parameter int TAM_INS   = 7,
    parameter int TAM_ALUOP = 2,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [TAM_INS-1:0]   OPCODE,
    input  logic                 IMEM_READY,
    input  logic                 DMEM_READY,
    output logic                 IMEM_REQ,
    output logic                 IRWRITE,
    output logic                 PCWRITE,
    output logic                 BRANCH,
    output logic                 MEMREAD,
    output logic                 MEMWRITE,
    output logic                 MEMTOREG,
    output logic                 ALUSRC,
    output logic                 REGWRITE,
    output logic [TAM_ALUOP-1:0] ALUOP,
    output logic [2:0]           STATE,
    output logic                 ILLEGAL,
    output logic                 TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_R     = 3'd1,
        C_I     = 3'd2,
        C_LOAD  = 3'd3,
        C_STORE = 3'd4,
        C_BR    = 3'd5,
        C_U     = 3'd6,
        C_J     = 3'd7
    } class_t;

    localparam logic [TAM_INS-1:0] OP_R     = TAM_INS'(7'b0110011);
    localparam logic [TAM_INS-1:0] OP_I     = TAM_INS'(7'b0010011);
    localparam logic [TAM_INS-1:0] OP_LOAD  = TAM_INS'(7'b0000011);
    localparam logic [TAM_INS-1:0] OP_STORE = TAM_INS'(7'b0100011);
    localparam logic [TAM_INS-1:0] OP_BR    = TAM_INS'(7'b1100011);
    localparam logic [TAM_INS-1:0] OP_LUI   = TAM_INS'(7'b0110111);
    localparam logic [TAM_INS-1:0] OP_AUIPC = TAM_INS'(7'b0010111);
    localparam logic [TAM_INS-1:0] OP_JAL   = TAM_INS'(7'b1101111);
    localparam logic [TAM_INS-1:0] OP_JALR  = TAM_INS'(7'b1100111);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t               r_state;
    state_t               w_state_nxt;
    class_t               r_class;
    class_t               w_dec_class;
    logic [7:0]           r_wait;
    logic                 r_illegal;
    logic                 r_timeout;
    logic                 w_waiting;
    logic                 w_expired;
    logic                 w_entry;
    logic [TAM_ALUOP-1:0] w_cls_aluop;
    logic                 w_cls_alusrc;

    // Opcode classification; only meaningful while OPCODE is valid (DECODE).
    always_comb begin
        w_dec_class = C_NONE;
        case (OPCODE)
            OP_R:              w_dec_class = C_R;
            OP_I:              w_dec_class = C_I;
            OP_LOAD:           w_dec_class = C_LOAD;
            OP_STORE:          w_dec_class = C_STORE;
            OP_BR:             w_dec_class = C_BR;
            OP_LUI, OP_AUIPC:  w_dec_class = C_U;
            OP_JAL, OP_JALR:   w_dec_class = C_J;
            default:           w_dec_class = C_NONE;
        endcase
    end

    always_comb begin
        w_cls_aluop  = TAM_ALUOP'(2'b01);
        w_cls_alusrc = 1'b1;
        case (r_class)
            C_R: begin
                w_cls_aluop  = TAM_ALUOP'(2'b00);
                w_cls_alusrc = 1'b0;
            end
            C_STORE: w_cls_aluop = TAM_ALUOP'(2'b10);
            C_BR:    w_cls_aluop = TAM_ALUOP'(2'b11);
            default: begin
                w_cls_aluop  = TAM_ALUOP'(2'b01);
                w_cls_alusrc = 1'b1;
            end
        endcase
    end

    // A memory request stays asserted while its ready is low; ready=1 in the
    // owning state completes the access, and ready pulses elsewhere are ignored.
    assign w_waiting = ((r_state == S_FETCH) && !IMEM_READY) ||
                       ((r_state == S_MEM)   && !DMEM_READY);
    assign w_expired = w_waiting && (r_wait == MAX_W);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (IMEM_READY)     w_state_nxt = S_DECODE;
                else if (w_expired) w_state_nxt = S_TRAP;
            end
            S_DECODE: w_state_nxt = (w_dec_class == C_NONE) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if ((r_class == C_LOAD) || (r_class == C_STORE)) w_state_nxt = S_MEM;
                else if (r_class == C_BR)                         w_state_nxt = S_FETCH;
                else                                              w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (DMEM_READY)     w_state_nxt = (r_class == C_LOAD) ? S_WB : S_FETCH;
                else if (w_expired) w_state_nxt = S_TRAP;
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_entry = ((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM)) &&
                     (w_state_nxt != r_state);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_class   <= C_NONE;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) r_class <= w_dec_class;
            if (w_entry)
                r_wait <= 8'd0;
            else if (w_waiting && !w_expired)
                r_wait <= r_wait + 8'd1;
            if ((r_state == S_DECODE) && (w_dec_class == C_NONE)) r_illegal <= 1'b1;
            if (w_expired) r_timeout <= 1'b1;
        end
    end

    // Moore outputs; IRWRITE and the STORE PCWRITE follow the ready of their own state.
    always_comb begin
        IMEM_REQ = 1'b0;
        IRWRITE  = 1'b0;
        PCWRITE  = 1'b0;
        BRANCH   = 1'b0;
        MEMREAD  = 1'b0;
        MEMWRITE = 1'b0;
        MEMTOREG = 1'b0;
        ALUSRC   = 1'b0;
        REGWRITE = 1'b0;
        ALUOP    = '0;
        case (r_state)
            S_FETCH: begin
                IMEM_REQ = 1'b1;
                IRWRITE  = IMEM_READY;
            end
            S_EXEC: begin
                ALUOP  = w_cls_aluop;
                ALUSRC = w_cls_alusrc;
                if (r_class == C_BR) begin
                    BRANCH  = 1'b1;
                    PCWRITE = 1'b1;
                end
            end
            S_MEM: begin
                ALUOP  = w_cls_aluop;
                ALUSRC = w_cls_alusrc;
                if (r_class == C_LOAD) begin
                    MEMREAD = 1'b1;
                end else begin
                    MEMWRITE = 1'b1;
                    PCWRITE  = DMEM_READY;
                end
            end
            S_WB: begin
                ALUOP    = w_cls_aluop;
                ALUSRC   = w_cls_alusrc;
                REGWRITE = 1'b1;
                PCWRITE  = 1'b1;
                MEMTOREG = (r_class == C_LOAD);
            end
            default: ;
        endcase
    end

    assign STATE   = r_state;
    assign ILLEGAL = r_illegal;
    assign TIMEOUT = r_timeout;

endmodule
